// File: rtl/sliced_logic_unit_if.sv
// Start/done bus between the ALU controller (master) and the sliced logic unit (slave).
// Operands are sampled only on an accepted start; result/zero are valid from done onward.
interface sliced_logic_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR) that evaluates SLICE bits per cycle.
// Handshake: start is taken only while idle (busy=0); done pulses one cycle with result/zero valid.
module sliced_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sliced_logic_unit_if.slave  bus,
  output logic [1:0]          state_dbg
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSL - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $fatal(1, "sliced_logic_unit: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  int               slice_base;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] f_sl;
  logic [WIDTH-1:0] work_merged;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    zero_d   = zero_q;

    slice_base = int'(cnt_q) * SLICE;
    a_sl       = a_q[slice_base +: SLICE];
    b_sl       = b_q[slice_base +: SLICE];
    case (op_q)
      2'b00:   f_sl = a_sl & b_sl;
      2'b01:   f_sl = a_sl | b_sl;
      2'b10:   f_sl = a_sl ^ b_sl;
      default: f_sl = ~(a_sl | b_sl);
    endcase
    // Completed word with the current slice merged in, used for the final load.
    work_merged = work_q;
    work_merged[slice_base +: SLICE] = f_sl;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          work_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d = work_merged;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = work_merged;
          zero_d   = (work_merged == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Directed bench for sliced_logic_unit in three geometries: 32/8, 32/32 and 64/16.
module tb_sliced_logic_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sliced_logic_unit_if #(.WIDTH(32)) if_a ();
  sliced_logic_unit_if #(.WIDTH(32)) if_b ();
  sliced_logic_unit_if #(.WIDTH(64)) if_c ();

  logic [1:0] st_a, st_b, st_c;

  sliced_logic_unit #(.WIDTH(32), .SLICE(8))  dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a), .state_dbg(st_a));
  sliced_logic_unit #(.WIDTH(32), .SLICE(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b), .state_dbg(st_b));
  sliced_logic_unit #(.WIDTH(64), .SLICE(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c), .state_dbg(st_c));

  logic [2:0]  start_v;
  logic [1:0]  op_v;
  logic [63:0] a_v, b_v;

  assign if_a.start = start_v[0];
  assign if_a.op    = op_v;
  assign if_a.a     = a_v[31:0];
  assign if_a.b     = b_v[31:0];
  assign if_b.start = start_v[1];
  assign if_b.op    = op_v;
  assign if_b.a     = a_v[31:0];
  assign if_b.b     = b_v[31:0];
  assign if_c.start = start_v[2];
  assign if_c.op    = op_v;
  assign if_c.a     = a_v;
  assign if_c.b     = b_v;

  int          sel;
  logic        done_m, busy_m, zero_m;
  logic [63:0] result_m;
  logic [1:0]  state_m;

  always_comb begin
    done_m   = if_a.done;
    busy_m   = if_a.busy;
    zero_m   = if_a.zero;
    result_m = {32'b0, if_a.result};
    state_m  = st_a;
    case (sel)
      1: begin
        done_m   = if_b.done;
        busy_m   = if_b.busy;
        zero_m   = if_b.zero;
        result_m = {32'b0, if_b.result};
        state_m  = st_b;
      end
      2: begin
        done_m   = if_c.done;
        busy_m   = if_c.busy;
        zero_m   = if_c.zero;
        result_m = if_c.result;
        state_m  = st_c;
      end
      default: ;
    endcase
  end

  // Scoreboard
  logic [63:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation on instance s and checks latency, result, zero and the done pulse.
  // With disturb set, start is re-pulsed and operands/op are scrambled throughout RUN.
  task automatic run_op(input int s, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int exp_lat, input logic [63:0] exp_res,
                        input bit disturb);
    int          n;
    int          pulses;
    logic [63:0] prev_res;
    logic [63:0] want;
    sel = s;
    exp_q.push_back(exp_res);
    @(negedge clk);
    prev_res   = result_m;
    start_v[s] = 1'b1;
    op_v       = op;
    a_v        = a;
    b_v        = b;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    check("busy_after_accept", 64'(busy_m), 64'd1);
    n = 0;
    while (n < 20 && !done_m) begin
      check("result_stable_in_run", result_m, prev_res);
      if (disturb) begin
        start_v[s] = 1'b1;
        a_v        = ~a;
        b_v        = ~b;
        op_v       = ~op;
      end
      @(posedge clk); #1;
      n++;
    end
    start_v[s] = 1'b0;
    want = exp_q.pop_front();
    check("latency", 64'(n), 64'(exp_lat));
    check("result", result_m, want);
    check("zero", 64'(zero_m), 64'(want == 64'd0));
    check("busy_in_done", 64'(busy_m), 64'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done_m), 64'd0);
    check("idle_after_done", 64'(busy_m), 64'd0);
    if (disturb) begin
      pulses = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (done_m) pulses++;
      end
      check("no_extra_done", 64'(pulses), 64'd0);
      check("result_held", result_m, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    int pulses;
    int d[8];

    rst_n   = 1'b0;
    start_v = '0;
    op_v    = 2'b00;
    a_v     = '0;
    b_v     = '0;
    sel     = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_done", 64'(done_m), 64'd0);
    check("rst_result", result_m, 64'd0);
    check("rst_zero", 64'(zero_m), 64'd1);
    check("rst_state", 64'(state_m), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 32/8 directed vectors
    run_op(0, 2'b00, 64'd47, 64'd25, 4, 64'd9, 1'b0);
    run_op(0, 2'b00, 64'h42220225, 64'h4002028A, 4, 64'h40020200, 1'b0);
    run_op(0, 2'b01, 64'h42220225, 64'h4002028A, 4, 64'h422202AF, 1'b0);
    run_op(0, 2'b10, 64'hFFFFFFFF, 64'hFFFFFFFF, 4, 64'h0, 1'b0);
    run_op(0, 2'b11, 64'h0, 64'h0, 4, 64'hFFFFFFFF, 1'b0);
    run_op(0, 2'b10, 64'h0F0F00FF, 64'h00FFFF00, 4, 64'h0FF0FFFF, 1'b0);
    run_op(0, 2'b11, 64'h12345678, 64'h0000FFFF, 4, 64'hEDCB0000, 1'b0);

    // Start and operand changes while busy are ignored
    run_op(0, 2'b01, 64'h00A0000C, 64'h0B000500, 4, 64'h0BA0050C, 1'b1);

    // Reset mid-RUN at cnt==2
    sel = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    op_v       = 2'b01;
    a_v        = 64'h11223344;
    b_v        = 64'h55667788;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_result", result_m, 64'd0);
    check("abort_zero", 64'(zero_m), 64'd1);
    check("abort_busy", 64'(busy_m), 64'd0);
    check("abort_state", 64'(state_m), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_m) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op(0, 2'b00, 64'd47, 64'd25, 4, 64'd9, 1'b0);

    // Back-to-back with start held high: one op every 6 cycles
    sel = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    op_v       = 2'b01;
    a_v        = 64'h000000F0;
    b_v        = 64'h0000000F;
    cyc = 0;
    k   = 0;
    repeat (20) begin
      @(posedge clk); #1;
      cyc++;
      if (done_m && k < 8) begin
        d[k] = cyc;
        k++;
        check("b2b_result", result_m, 64'h000000FF);
      end
    end
    start_v[0] = 1'b0;
    check("b2b_count", 64'(k), 64'd3);
    if (k >= 3) begin
      check("b2b_interval_1", 64'(d[1] - d[0]), 64'd6);
      check("b2b_interval_2", 64'(d[2] - d[1]), 64'd6);
    end
    repeat (8) @(posedge clk);
    #1;
    check("b2b_idle", 64'(busy_m), 64'd0);

    // 32/32: single-slice geometry
    run_op(1, 2'b00, 64'd47, 64'd25, 1, 64'd9, 1'b0);
    run_op(1, 2'b11, 64'h12345678, 64'h0000FFFF, 1, 64'hEDCB0000, 1'b0);

    // 64/16
    run_op(2, 2'b00, 64'd47, 64'd25, 4, 64'd9, 1'b0);
    run_op(2, 2'b10, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFFFFFF, 4, 64'hF0F00F0F_EDCBA987, 1'b0);
    run_op(2, 2'b11, 64'h0, 64'h0, 4, 64'hFFFFFFFF_FFFFFFFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
